// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared fetch constants and the fetch-queue entry type.
package mycpu_pkg;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int FS_TO_DS_BUS_WD = 65;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fs_entry_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction SRAM port, redirect input and fetch-to-decode handshake.
interface if_stage_if;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;
  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output fs_to_ds_valid, fs_pc, fs_inst, fs_adef,
    input  inst_sram_rdata, br_taken, br_target, ds_allowin
  );
  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  fs_to_ds_valid, fs_pc, fs_inst, fs_adef,
    output inst_sram_rdata, br_taken, br_target, ds_allowin
  );
endinterface

// File: rtl/if_fifo.sv
// if_fifo: in-order fetch queue with flush; push and pop may share a cycle.
module if_fifo import mycpu_pkg::*; #(
  parameter int FQ_DEPTH = 2,
  parameter type T = fs_entry_t
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  T                          din,
  output T                          dout,
  output logic [$clog2(FQ_DEPTH):0] count
);
  localparam int AW = $clog2(FQ_DEPTH);
  T mem [FQ_DEPTH];
  logic [AW-1:0] rptr, wptr;
  always_comb dout = mem[rptr];
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk)
    if (reset || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + AW'(pop);
      wptr  <= wptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, 1-cycle instruction SRAM requests and fetch queue toward decode.
// Define IF_ADEF_EN to turn misaligned redirect targets into ADEF entries that halt fetch.
module if_stage #(
  parameter int          FQ_DEPTH = 2,
  parameter logic [31:0] RESET_PC = mycpu_pkg::RESET_PC
) (
  input logic       clk,
  input logic       reset,
  if_stage_if.master bus
);
  import mycpu_pkg::*;
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_O = (CW+1)'(FQ_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
  logic [31:0] pc, req_pc, tgt;
  logic        pending, cancel, halted, adef_req, tgt_bad;
  logic        en, push, pop, valid;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  fs_entry_t din, head;
`ifdef IF_ADEF_EN
  always_comb begin
    tgt     = bus.br_target;
    tgt_bad = |bus.br_target[1:0];
  end
`else
  always_comb begin
    tgt     = {bus.br_target[31:2], 2'b00};
    tgt_bad = 1'b0;
  end
`endif
  always_comb begin
    valid = count != '0;
    pop   = valid && bus.ds_allowin;
    occ   = {1'b0, count} + (CW+1)'(pending) - (CW+1)'(pop);
    en    = !reset && !bus.br_taken && !halted && !adef_req && occ < DEPTH_O;
    push  = !bus.br_taken && (adef_req ? count < DEPTH_C : pending && !cancel);
    din   = adef_req ? fs_entry_t'{pc: pc, inst: 32'h0, adef: 1'b1}
                     : fs_entry_t'{pc: req_pc, inst: bus.inst_sram_rdata, adef: 1'b0};
  end
  // A redirect flushes the queue; its pop and any stale return are dropped.
  always_ff @(posedge clk)
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      pending  <= 1'b0;
      cancel   <= 1'b0;
      halted   <= 1'b0;
      adef_req <= 1'b0;
    end else if (bus.br_taken) begin
      pc       <= tgt;
      pending  <= 1'b0;
      cancel   <= pending;
      halted   <= 1'b0;
      adef_req <= tgt_bad;
    end else begin
      if (en) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      pending  <= en;
      cancel   <= 1'b0;
      halted   <= halted || (push && adef_req);
      adef_req <= adef_req && !push;
    end
  if_fifo #(.FQ_DEPTH(FQ_DEPTH), .T(fs_entry_t)) u_fifo (
    .clk(clk), .reset(reset), .flush(bus.br_taken), .push(push), .pop(pop),
    .din(din), .dout(head), .count(count)
  );
  always_comb begin
    bus.inst_sram_en    = en;
    bus.inst_sram_we    = 1'b0;
    bus.inst_sram_addr  = {pc[31:2], 2'b00};
    bus.inst_sram_wdata = '0;
    bus.fs_to_ds_valid  = valid;
    bus.fs_pc           = valid ? head.pc : '0;
    bus.fs_inst         = valid ? head.inst : '0;
    bus.fs_adef         = valid && head.adef;
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch start-up, stall, redirect, flush, wrap and ADEF.
module tb_if_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errs = 0, checks = 0;
  if_stage_if bus();
  if_stage #(.FQ_DEPTH(2), .RESET_PC(32'h1c00_0000)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.inst_sram_en) bus.inst_sram_rdata <= ~bus.inst_sram_addr;
  task step;
    @(posedge clk);
    #1;
  endtask
  task test_reset;
    reset = 1; bus.ds_allowin = 1; bus.br_taken = 0; bus.br_target = '0;
    repeat (2) step();
    checks++; if (bus.inst_sram_en !== 1'b0) begin errs++; $display("FAIL reset_en got %b want 0", bus.inst_sram_en); end
    checks++; if (bus.fs_to_ds_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", bus.fs_to_ds_valid); end
    checks++; if (bus.fs_pc !== 32'h0 || bus.fs_inst !== 32'h0 || bus.fs_adef !== 1'b0) begin errs++; $display("FAIL reset_head got %h/%h/%b want 0/0/0", bus.fs_pc, bus.fs_inst, bus.fs_adef); end
    checks++; if (bus.inst_sram_we !== 1'b0 || bus.inst_sram_wdata !== 32'h0) begin errs++; $display("FAIL reset_we got %b/%h want 0/0", bus.inst_sram_we, bus.inst_sram_wdata); end
  endtask
  task test_startup;
    logic [31:0] e;
    reset = 0; #1;
    for (int k = 0; k < 6; k++) begin
      e = 32'h1c00_0000 + 32'(4 * k);
      checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== e) begin errs++; $display("FAIL start_req%0d got %b/%h want 1/%h", k, bus.inst_sram_en, bus.inst_sram_addr, e); end
      checks++; if (bus.fs_to_ds_valid !== (k >= 2)) begin errs++; $display("FAIL start_valid%0d got %b want %b", k, bus.fs_to_ds_valid, k >= 2); end
      if (k >= 2) begin
        e = 32'h1c00_0000 + 32'(4 * (k - 2));
        checks++; if (bus.fs_pc !== e || bus.fs_inst !== ~e) begin errs++; $display("FAIL start_head%0d got %h/%h want %h/%h", k, bus.fs_pc, bus.fs_inst, e, ~e); end
      end
      step();
    end
  endtask
  task test_reset_mid;
    reset = 1; step();
    checks++; if (bus.inst_sram_en !== 1'b0 || bus.fs_to_ds_valid !== 1'b0) begin errs++; $display("FAIL midreset_idle got %b/%b want 0/0", bus.inst_sram_en, bus.fs_to_ds_valid); end
    reset = 0; #1;
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c00_0000) begin errs++; $display("FAIL midreset_req got %b/%h want 1/1c000000", bus.inst_sram_en, bus.inst_sram_addr); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b0) begin errs++; $display("FAIL midreset_stale got %b want 0", bus.fs_to_ds_valid); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0000) begin errs++; $display("FAIL midreset_head got %b/%h want 1/1c000000", bus.fs_to_ds_valid, bus.fs_pc); end
  endtask
  task test_stall;
    logic [31:0] e;
    reset = 1; bus.ds_allowin = 0; step();
    reset = 0; #1;
    step(); step();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.inst_sram_en !== 1'b0) begin errs++; $display("FAIL stall_en%0d got %b want 0", k, bus.inst_sram_en); end
      checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0000 || bus.fs_inst !== ~32'h1c00_0000) begin errs++; $display("FAIL stall_hold%0d got %b/%h/%h want 1/1c000000/e3ffffff", k, bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst); end
      step();
    end
    bus.ds_allowin = 1; #1;
    for (int k = 0; k < 4; k++) begin
      e = 32'h1c00_0000 + 32'(4 * k);
      checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== e || bus.fs_inst !== ~e) begin errs++; $display("FAIL resume_head%0d got %b/%h/%h want 1/%h/%h", k, bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, e, ~e); end
      checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== e + 32'd8) begin errs++; $display("FAIL resume_req%0d got %b/%h want 1/%h", k, bus.inst_sram_en, bus.inst_sram_addr, e + 32'd8); end
      step();
    end
  endtask
  task test_redirect;
    bus.br_taken = 1; bus.br_target = 32'h1c00_0100; #1;
    checks++; if (bus.inst_sram_en !== 1'b0) begin errs++; $display("FAIL redir_noissue got %b want 0", bus.inst_sram_en); end
    step(); bus.br_taken = 0; #1;
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c00_0100 || bus.fs_to_ds_valid !== 1'b0) begin errs++; $display("FAIL redir_t1 got %b/%h/%b want 1/1c000100/0", bus.inst_sram_en, bus.inst_sram_addr, bus.fs_to_ds_valid); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b0 || bus.inst_sram_addr !== 32'h1c00_0104) begin errs++; $display("FAIL redir_t2 got %b/%h want 0/1c000104", bus.fs_to_ds_valid, bus.inst_sram_addr); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0100 || bus.fs_inst !== ~32'h1c00_0100) begin errs++; $display("FAIL redir_t3 got %b/%h/%h want 1/1c000100/e3fffeff", bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0104) begin errs++; $display("FAIL redir_t4 got %b/%h want 1/1c000104", bus.fs_to_ds_valid, bus.fs_pc); end
  endtask
  task test_flush_full;
    bus.ds_allowin = 0; bus.br_taken = 1; bus.br_target = 32'h1c00_0300;
    step(); bus.br_taken = 0; #1;
    repeat (3) step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0300 || bus.inst_sram_en !== 1'b0) begin errs++; $display("FAIL full_state got %b/%h/%b want 1/1c000300/0", bus.fs_to_ds_valid, bus.fs_pc, bus.inst_sram_en); end
    bus.ds_allowin = 1; bus.br_taken = 1; bus.br_target = 32'h1c00_0400;
    step(); bus.br_taken = 0; #1;
    checks++; if (bus.fs_to_ds_valid !== 1'b0 || bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c00_0400) begin errs++; $display("FAIL flush_t1 got %b/%b/%h want 0/1/1c000400", bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b0) begin errs++; $display("FAIL flush_t2 got %b want 0", bus.fs_to_ds_valid); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0400) begin errs++; $display("FAIL flush_t3 got %b/%h want 1/1c000400", bus.fs_to_ds_valid, bus.fs_pc); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0404) begin errs++; $display("FAIL flush_t4 got %b/%h want 1/1c000404", bus.fs_to_ds_valid, bus.fs_pc); end
  endtask
  task test_wrap;
    bus.br_taken = 1; bus.br_target = 32'hffff_fffc;
    step(); bus.br_taken = 0; #1;
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'hffff_fffc) begin errs++; $display("FAIL wrap_req0 got %b/%h want 1/fffffffc", bus.inst_sram_en, bus.inst_sram_addr); end
    step();
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h0) begin errs++; $display("FAIL wrap_req1 got %b/%h want 1/00000000", bus.inst_sram_en, bus.inst_sram_addr); end
    step();
    checks++; if (bus.fs_pc !== 32'hffff_fffc || bus.fs_inst !== 32'h3) begin errs++; $display("FAIL wrap_head0 got %h/%h want fffffffc/00000003", bus.fs_pc, bus.fs_inst); end
    step();
    checks++; if (bus.fs_pc !== 32'h0 || bus.fs_inst !== 32'hffff_ffff) begin errs++; $display("FAIL wrap_head1 got %h/%h want 00000000/ffffffff", bus.fs_pc, bus.fs_inst); end
  endtask
`ifdef IF_ADEF_EN
  task test_adef;
    bus.ds_allowin = 0; bus.br_taken = 1; bus.br_target = 32'h1c00_0102;
    step(); bus.br_taken = 0; #1;
    checks++; if (bus.inst_sram_en !== 1'b0 || bus.fs_to_ds_valid !== 1'b0) begin errs++; $display("FAIL adef_t1 got %b/%b want 0/0", bus.inst_sram_en, bus.fs_to_ds_valid); end
    step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_adef !== 1'b1 || bus.fs_pc !== 32'h1c00_0102 || bus.fs_inst !== 32'h0) begin errs++; $display("FAIL adef_entry got %b/%b/%h/%h want 1/1/1c000102/0", bus.fs_to_ds_valid, bus.fs_adef, bus.fs_pc, bus.fs_inst); end
    checks++; if (bus.inst_sram_en !== 1'b0) begin errs++; $display("FAIL adef_en got %b want 0", bus.inst_sram_en); end
    bus.ds_allowin = 1; #1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (bus.inst_sram_en !== 1'b0 || bus.fs_to_ds_valid !== 1'b0) begin errs++; $display("FAIL adef_halt%0d got %b/%b want 0/0", k, bus.inst_sram_en, bus.fs_to_ds_valid); end
    end
    bus.br_taken = 1; bus.br_target = 32'h1c00_0200;
    step(); bus.br_taken = 0; #1;
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c00_0200) begin errs++; $display("FAIL adef_restart got %b/%h want 1/1c000200", bus.inst_sram_en, bus.inst_sram_addr); end
    step(); step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0200 || bus.fs_adef !== 1'b0) begin errs++; $display("FAIL adef_resume got %b/%h/%b want 1/1c000200/0", bus.fs_to_ds_valid, bus.fs_pc, bus.fs_adef); end
  endtask
`else
  task test_adef;
    bus.ds_allowin = 1; bus.br_taken = 1; bus.br_target = 32'h1c00_0102;
    step(); bus.br_taken = 0; #1;
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c00_0100) begin errs++; $display("FAIL noadef_req got %b/%h want 1/1c000100", bus.inst_sram_en, bus.inst_sram_addr); end
    step(); step();
    checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h1c00_0100 || bus.fs_adef !== 1'b0) begin errs++; $display("FAIL noadef_head got %b/%h/%b want 1/1c000100/0", bus.fs_to_ds_valid, bus.fs_pc, bus.fs_adef); end
  endtask
`endif
  initial begin
    test_reset();
    test_startup();
    test_reset_mid();
    test_stall();
    test_redirect();
    test_flush_full();
    test_wrap();
    test_adef();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
